// File: rtl/miriscv_data_bus.sv
// Data-side memory subsystem: byte-writable RAM plus a memory-mapped timer.
// Every access completes in one cycle; read data and the error flag are registered.
module miriscv_data_bus #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] TIMER_BASE = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        timer_irq_o
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_CMP    = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } timer_reg_e;

    logic [31:0]   r_mem [RAM_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_irq;
    logic [31:0]   r_count;
    logic [31:0]   r_cmp;
    logic [2:0]    r_ctrl;
    logic          r_match;

    logic          w_ram_hit;
    logic          w_tmr_hit;
    logic [AW-1:0] w_ram_idx;
    timer_reg_e    w_reg;
    logic          w_rd;
    logic          w_ram_we;
    logic          w_tmr_wr;
    logic          w_tmr_be_bad;
    logic          w_unmapped;
    logic [31:0]   w_wmask;
    logic [31:0]   w_tmr_rdata;
    logic [31:0]   w_count_nxt;
    logic          w_match_nxt;
    logic          w_cmp_hit;
    logic          w_unused_addr;

    // RAM base is aligned to its size, so an upper-bit compare is the range check.
    assign w_ram_hit    = (data_addr_i[31:AW+2] == RAM_BASE[31:AW+2]);
    assign w_tmr_hit    = (data_addr_i[31:4] == TIMER_BASE[31:4]) && !w_ram_hit;
    assign w_ram_idx    = data_addr_i[AW+1:2];
    assign w_reg        = timer_reg_e'(data_addr_i[3:2]);
    assign w_unused_addr = ^data_addr_i[1:0];

    assign w_rd         = data_req_i && !data_we_i && (w_ram_hit || w_tmr_hit);
    assign w_ram_we     = data_req_i && data_we_i && w_ram_hit;
    assign w_tmr_wr     = data_req_i && data_we_i && w_tmr_hit && (data_be_i == 4'hF);
    assign w_tmr_be_bad = data_req_i && data_we_i && w_tmr_hit
                          && (data_be_i != 4'h0) && (data_be_i != 4'hF);
    assign w_unmapped   = data_req_i && !w_ram_hit && !w_tmr_hit;

    assign w_wmask = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                      {8{data_be_i[1]}}, {8{data_be_i[0]}}};

    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= (r_mem[w_ram_idx] & ~w_wmask) | (data_wdata_i & w_wmask);
        end
    end

    always_comb begin
        w_tmr_rdata = '0;
        unique case (w_reg)
            REG_COUNT:  w_tmr_rdata = r_count;
            REG_CMP:    w_tmr_rdata = r_cmp;
            REG_CTRL:   w_tmr_rdata = {29'd0, r_ctrl};
            REG_STATUS: w_tmr_rdata = {31'd0, r_match};
        endcase
    end

    assign w_cmp_hit = r_ctrl[0] && (r_count == r_cmp);

    // Software COUNT write has top priority; a match set outranks a same-cycle w1c.
    always_comb begin
        w_count_nxt = r_count;
        if (w_tmr_wr && (w_reg == REG_COUNT)) begin
            w_count_nxt = data_wdata_i;
        end else if (r_ctrl[0]) begin
            w_count_nxt = (w_cmp_hit && r_ctrl[1]) ? '0 : r_count + 32'd1;
        end

        w_match_nxt = r_match;
        if (w_cmp_hit) begin
            w_match_nxt = 1'b1;
        end else if (w_tmr_wr && (w_reg == REG_STATUS) && data_wdata_i[0]) begin
            w_match_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_irq   <= 1'b0;
            r_count <= '0;
            r_cmp   <= '0;
            r_ctrl  <= '0;
            r_match <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_match <= w_match_nxt;
            if (w_tmr_wr && (w_reg == REG_CMP)) begin
                r_cmp <= data_wdata_i;
            end
            if (w_tmr_wr && (w_reg == REG_CTRL)) begin
                r_ctrl <= data_wdata_i[2:0];
            end
            r_irq <= r_match && r_ctrl[2];
            r_err <= w_unmapped || w_tmr_be_bad;
            if (w_rd) begin
                r_rdata <= w_ram_hit ? r_mem[w_ram_idx] : w_tmr_rdata;
            end
        end
    end

    assign data_rdata_o = r_rdata;
    assign data_err_o   = r_err;
    assign timer_irq_o  = r_irq;

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Scoreboard bench for miriscv_data_bus: a driver steps a behavioural model and
// queues expected responses; a monitor compares them one cycle after each edge.
module tb_miriscv_data_bus;

    localparam int unsigned RW         = 256;
    localparam logic [31:0] TB_RAM     = 32'h0000_0000;
    localparam logic [31:0] TB_TIMER   = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        arstn = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        err;
    logic        irq;

    miriscv_data_bus #(
        .RAM_WORDS (RW),
        .RAM_BASE  (TB_RAM),
        .TIMER_BASE(TB_TIMER)
    ) dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .data_req_i  (req),
        .data_we_i   (we),
        .data_be_i   (be),
        .data_addr_i (addr),
        .data_wdata_i(wdata),
        .data_rdata_o(rdata),
        .data_err_o  (err),
        .timer_irq_o (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_count = '0;
    logic [31:0] m_cmp   = '0;
    logic [2:0]  m_ctrl  = '0;
    logic        m_match = 1'b0;
    logic [31:0] m_rdata = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count = '0;
        m_cmp   = '0;
        m_ctrl  = '0;
        m_match = 1'b0;
        m_rdata = '0;
    endtask

    task automatic model_step(input logic r, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d, output exp_t e);
        bit          ram, tmr, hit, tw;
        logic [1:0]  off;
        int          idx;
        logic [31:0] nxt, tmp;
        ram = ((a - TB_RAM) < 32'(4 * RW));
        tmr = !ram && ((a & ~32'hF) == TB_TIMER);
        off = a[3:2];
        idx = int'((a - TB_RAM) >> 2);
        hit = m_ctrl[0] && (m_count == m_cmp);
        tw  = r && w && tmr && (b == 4'hF);

        e.irq = m_match && m_ctrl[2];
        e.err = r && (!(ram || tmr) || (tmr && w && b != 4'h0 && b != 4'hF));
        if (r && !w && ram) begin
            m_rdata = m_mem[idx];
        end else if (r && !w && tmr) begin
            case (off)
                2'd0: m_rdata = m_count;
                2'd1: m_rdata = m_cmp;
                2'd2: m_rdata = {29'd0, m_ctrl};
                default: m_rdata = {31'd0, m_match};
            endcase
        end
        e.rdata = m_rdata;

        if (!m_ctrl[0])                nxt = m_count;
        else if (hit && m_ctrl[1])     nxt = 32'd0;
        else                           nxt = m_count + 32'd1;
        if (tw && off == 2'd0) nxt = d;
        if (tw && off == 2'd3 && d[0]) m_match = 1'b0;
        if (hit) m_match = 1'b1;
        if (tw && off == 2'd1) m_cmp = d;
        if (tw && off == 2'd2) m_ctrl = d[2:0];
        m_count = nxt;

        if (r && w && ram) begin
            tmp = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            if (b[0]) tmp[7:0]   = d[7:0];
            if (b[1]) tmp[15:8]  = d[15:8];
            if (b[2]) tmp[23:16] = d[23:16];
            if (b[3]) tmp[31:24] = d[31:24];
            m_mem[idx] = tmp;
        end
    endtask

    task automatic do_op(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        req = r; we = w; be = b; addr = a; wdata = d;
        model_step(r, w, b, a, d, e);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "idle");
    endtask

    task automatic twr(input logic [1:0] off, input logic [31:0] d, input string tag);
        do_op(1'b1, 1'b1, 4'hF, TB_TIMER + {28'd0, off, 2'b00}, d, tag);
    endtask

    task automatic trd(input logic [1:0] off, input string tag);
        do_op(1'b1, 1'b0, 4'h0, TB_TIMER + {28'd0, off, 2'b00}, 32'h0, tag);
    endtask

    // Monitor: every queued expectation is compared one step after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check32({e.tag, " rdata"}, rdata, e.rdata);
                check32({e.tag, " err"}, {31'd0, err}, {31'd0, e.err});
                check32({e.tag, " irq"}, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        w;
        int          k, cat;

        repeat (2) @(negedge clk);
        check32("reset rdata", rdata, 32'h0);
        check32("reset err", {31'd0, err}, 32'h0);
        check32("reset irq", {31'd0, irq}, 32'h0);
        arstn = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            k = (i == 16) ? 255 : i;
            do_op(1'b1, 1'b1, 4'hF, TB_RAM + 32'(k * 4), $urandom, "ram_init");
        end

        // RAM byte-lane merge and hold behaviour
        do_op(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr_full");
        do_op(1'b1, 1'b1, 4'b0010, 32'h10, 32'h55555555, "wr_lane1");
        do_op(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd_merge");
        idle(3);
        do_op(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "wr_be0");
        do_op(1'b1, 1'b0, 4'h0, 32'(4 * RW), 32'h0, "rd_past_end");
        do_op(1'b1, 1'b0, 4'hF, 32'(4 * RW - 4), 32'h0, "rd_last_word");
        do_op(1'b1, 1'b0, 4'h3, 32'h13, 32'h0, "rd_lowbits");

        // Match with clear-on-match and irq, then w1c
        twr(2'd2, 32'h0, "ctrl_off");
        twr(2'd0, 32'h0, "count0");
        twr(2'd1, 32'd5, "cmp5");
        twr(2'd2, 32'h7, "ctrl7");
        for (int i = 0; i < 8; i++) trd(2'd0, "count_run");
        trd(2'd3, "status_set");
        twr(2'd3, 32'h1, "status_w1c");
        idle(2);
        twr(2'd2, 32'h0, "ctrl_stop");

        // Wrap and illegal byte enables
        twr(2'd1, 32'd5, "cmp_far");
        twr(2'd0, 32'hFFFF_FFFE, "count_wrap");
        twr(2'd2, 32'h1, "ctrl_en");
        for (int i = 0; i < 3; i++) trd(2'd0, "count_wrap_rd");
        do_op(1'b1, 1'b1, 4'b0011, TB_TIMER + 32'h8, 32'h0, "ctrl_be_bad");
        trd(2'd2, "ctrl_unchanged");

        // Same-cycle w1c vs match, and COUNT write vs increment
        twr(2'd1, 32'd10, "cmp10");
        twr(2'd3, 32'h1, "status_clr");
        twr(2'd0, 32'h0, "count_restart");
        idle(10);
        twr(2'd3, 32'h1, "w1c_at_match");
        trd(2'd3, "status_kept");
        twr(2'd0, 32'd100, "count100");
        trd(2'd0, "count100_rd");

        // Asynchronous reset mid-count with irq asserted
        twr(2'd2, 32'h0, "ctrl_off2");
        twr(2'd1, 32'd3, "cmp3");
        twr(2'd0, 32'h0, "count0b");
        twr(2'd2, 32'h5, "ctrl5");
        idle(8);
        trd(2'd1, "cmp_rd");
        do_op(1'b1, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, "unmapped_pre_reset");
        idle(1);
        @(posedge clk);
        #2;
        check32("irq before reset", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
        arstn = 1'b1;
        #1;
        check32("async reset rdata", rdata, 32'h0);
        check32("async reset err", {31'd0, err}, 32'h0);
        check32("async reset irq", {31'd0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        arstn = 1'b0;
        trd(2'd0, "count_after_reset");
        trd(2'd2, "ctrl_after_reset");
        do_op(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "ram_retained");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            cat = $urandom_range(0, 99);
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom);
            d   = $urandom;
            if (cat < 40) begin
                k = $urandom_range(0, 16);
                if (k == 16) k = 255;
                a = TB_RAM + 32'(k * 4) + 32'($urandom_range(0, 3));
                do_op(1'b1, w, b, a, d, "rnd_ram");
            end else if (cat < 75) begin
                a = TB_TIMER + 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) b = 4'hF;
                if (a[3:2] < 2'd2) d = 32'($urandom_range(0, 24));
                do_op(1'b1, w, b, a, d, "rnd_tmr");
            end else if (cat < 90) begin
                case ($urandom_range(0, 3))
                    0: a = 32'(4 * RW) + (32'($urandom) & 32'h0000_FFFC);
                    1: a = TB_TIMER + 32'h10;
                    2: a = 32'hFFFF_FFFC;
                    default: a = 32'h4000_0000 + (32'($urandom) & 32'h0FFF_FFFC);
                endcase
                do_op(1'b1, w, b, a, d, "rnd_unmapped");
            end else begin
                do_op(1'b0, w, b, TB_TIMER, d, "rnd_idle");
            end
        end
        idle(1);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miriscv_data_bus.md
Name: miriscv_data_bus

Overview:
Data-side memory subsystem that consumes the core's load/store memory protocol (req/we/be/addr/wdata) and returns read data one cycle later. It holds a byte-writable synchronous data RAM and a memory-mapped timer peripheral, and flags accesses to unmapped addresses. It sits directly downstream of the core's load/store unit and replaces a bare RAM on the data port.

Parameters:
RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two)
RAM_BASE, 32'h0000_0000, byte base address of RAM (aligned to 4*RAM_WORDS)
TIMER_BASE, 32'h8000_0000, byte base address of 16-byte timer register block

Ports:
clk_i  in  1  clock, all state updates on posedge
arstn_i  in  1  reset, asynchronous, active-high
data_req_i  in  1  access request, 1 = valid access this cycle
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables, bit n = byte lane n (bits 8n+7:8n)
data_addr_i  in  32  word-aligned byte address, bits [1:0] ignored
data_wdata_i  in  32  write data, already lane-replicated by requester
data_rdata_o  out  32  read data, registered
data_err_o  out  1  one-cycle pulse: unmapped or illegal access
timer_irq_o  out  1  timer interrupt, level

Behaviour:
- Reset (arstn_i=1, async): data_rdata_o=0, data_err_o=0, timer_irq_o=0, all timer regs=0. RAM contents not reset.
- Decode: RAM hit if addr in [RAM_BASE, RAM_BASE+4*RAM_WORDS); timer hit if addr[31:4]==TIMER_BASE[31:4]; else unmapped.
- RAM write: at posedge with req&we&hit, write each byte lane whose be bit is 1; other lanes unchanged. be=0000 writes nothing, no error.
- RAM read: req&!we&hit at edge N -> full 32-bit word on data_rdata_o after edge N (valid for cycle N+1). be ignored on reads.
- data_rdata_o holds last read value through writes, idle cycles and errors; it updates only on a mapped read.
- Timer regs (offset = addr[3:2]):
  0 COUNT  RW 32-bit counter
  1 CMP  RW compare value
  2 CTRL  RW bits[2:0]: [0] EN, [1] CLR_ON_MATCH, [2] IRQ_EN; other bits read 0
  3 STATUS  bit0 MATCH, write-1-to-clear; other bits read 0
- Timer writes require be=1111; any other nonzero be to a timer reg: write dropped, data_err_o pulses.
- Counter: when EN=1, COUNT increments by 1 every posedge, wrapping 32'hFFFF_FFFF -> 0.
- Match: when EN=1 and COUNT==CMP at an edge, set MATCH. If CLR_ON_MATCH=1, COUNT loads 0 at that edge instead of incrementing.
- Simultaneous events: a software write to COUNT beats increment and clear-on-match. Set of MATCH beats a w1c clear in the same cycle.
- A COUNT read returns the pre-edge value.
- timer_irq_o = registered (MATCH & IRQ_EN), one cycle after either changes.
- Unmapped access (read or write): no state change, data_rdata_o unchanged, data_err_o=1 for the cycle after the edge.
- data_err_o is otherwise 0. No back-pressure: every request completes in one cycle, so the requester's single-cycle stall is sufficient.
- Reset asserted mid-operation: timer and outputs clear immediately. A write in the reset cycle to RAM may or may not commit and is not checked.

Test Plan:
- Write 32'hDEADBEEF be=1111 to 0x10, then write 32'h55555555 be=0010 to 0x10, read 0x10 -> rdata=32'hDEAD55EF in the cycle after the read edge.
- Read 0x10 then idle 3 cycles with req=0 -> rdata stays 32'hDEAD55EF. Read RAM_BASE+4*RAM_WORDS -> err pulse 1 cycle, rdata unchanged.
- CMP=5, CTRL=3'b111, COUNT=0 -> MATCH set and COUNT=0 on the edge where COUNT was 5. timer_irq_o=1 one cycle later. Write STATUS=1 -> irq drops next cycle.
- COUNT=32'hFFFF_FFFE, EN=1 -> reads 32'hFFFF_FFFF then 0 (wrap). CTRL written with be=0011 -> err pulse, CTRL unchanged.
- Same-cycle STATUS w1c and match condition -> MATCH remains 1. Same-cycle COUNT write 100 and increment -> COUNT=100.
- Assert arstn_i mid-count with irq high -> COUNT, CTRL, irq, err, rdata all 0 immediately. RAM word at 0x10 retains 32'hDEAD55EF.
